// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter for the shared system memory bus: grants one requester,
// times the access with a wait-state counter and pulses done to the winner.
module mem_bus_arbiter #(
  parameter  int NUM_REQ = 3,
  parameter  int WAIT_W  = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [WAIT_W-1:0]  wait_cycles,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               busy,
  output logic               mem_strobe,
  output logic [NUM_REQ-1:0] done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   idx_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]   arb_idx;
  logic               access_end;

  // Lowest set index wins; index 0 has the highest priority.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] r);
    lowest_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign arb_idx = lowest_idx(req);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt;
    idx_d      = gnt_idx;
    cnt_d      = cnt_q;
    access_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = NUM_REQ'(1) << arb_idx;
          idx_d   = arb_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wait_cycles == '0) begin
          access_end = 1'b1;
        end else begin
          cnt_d   = wait_cycles - WAIT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) access_end = 1'b1;
        else             cnt_d      = cnt_q - WAIT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Completion: a locked burst keeps the bus, otherwise re-arbitrate with
    // no idle bubble, or release the bus when nobody is asking.
    if (access_end) begin
      if (lock[gnt_idx] && req[gnt_idx]) begin
        state_d = S_START;
      end else if (|req) begin
        gnt_d   = NUM_REQ'(1) << arb_idx;
        idx_d   = arb_idx;
        state_d = S_START;
      end else begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign mem_strobe = (state_q == S_START) || (state_q == S_WAIT);
  assign done       = access_end ? gnt : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table-driven bench for mem_bus_arbiter plus a hand-written
// maximum-length access sequence.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] lock;
  logic [3:0] wait_cycles;
  logic [2:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       mem_strobe;
  logic [2:0] done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_REQ(3), .WAIT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .wait_cycles(wait_cycles),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .busy       (busy),
    .mem_strobe (mem_strobe),
    .done       (done)
  );

  // One row: inputs held across one rising edge, then outputs expected after it.
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [3:0] wc;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       strobe;
    logic [2:0] done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] q, input logic [2:0] l, input logic [3:0] w,
                     input logic [2:0] g, input logic [1:0] i, input logic b, input logic s,
                     input logic [2:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.wc = w;
    v.gnt = g; v.idx = i; v.busy = b; v.strobe = s; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  strobes;
    bit  seen;

    reset = 1'b1; req = '0; lock = '0; wait_cycles = '0;

    //   rst req     lock    wc   gnt     idx b  s  done
    // reset state
    add(1, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    // single CPU access, wait 0, then release and idle indefinitely
    add(0, 3'b100, 3'b000, 0, 3'b100, 2, 1, 1, 3'b100);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    // DMA0 with 3 wait states: 4 strobe cycles, done only in the 4th
    add(0, 3'b001, 3'b000, 3, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 3, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 3, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 3, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b000, 3'b000, 3, 3'b000, 0, 0, 0, 3'b000);
    // priority 001 -> 010 -> 100 back to back, busy stays high
    add(0, 3'b111, 3'b000, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b110, 3'b000, 0, 3'b010, 1, 1, 1, 3'b010);
    add(0, 3'b100, 3'b000, 0, 3'b100, 2, 1, 1, 3'b100);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    // burst lock: 4 DMA0 accesses, CPU after lock and req[0] fall
    add(0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b101, 3'b001, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b100, 3'b000, 0, 3'b100, 2, 1, 1, 3'b100);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    // lock held but req dropped: lock is ignored, CPU takes over
    add(0, 3'b001, 3'b001, 0, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b100, 3'b001, 0, 3'b100, 2, 1, 1, 3'b100);
    add(0, 3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000);
    // no preemption: DMA0 arrives while CPU access runs
    add(0, 3'b100, 3'b000, 1, 3'b100, 2, 1, 1, 3'b000);
    add(0, 3'b101, 3'b000, 1, 3'b100, 2, 1, 1, 3'b100);
    add(0, 3'b001, 3'b000, 1, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 1, 3'b001, 0, 1, 1, 3'b001);
    add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 3'b000);
    // reset mid-access (wait 5, cnt=2): abort, no done ever
    add(0, 3'b001, 3'b000, 5, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 5, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 5, 3'b001, 0, 1, 1, 3'b000);
    add(0, 3'b001, 3'b000, 5, 3'b001, 0, 1, 1, 3'b000);
    add(1, 3'b001, 3'b000, 5, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 3'b000, 5, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 3'b000, 5, 3'b000, 0, 0, 0, 3'b000);
    // wait_cycles sampled only in START: 2 then 7 -> exactly 3 cycles
    add(0, 3'b010, 3'b000, 2, 3'b010, 1, 1, 1, 3'b000);
    add(0, 3'b010, 3'b000, 2, 3'b010, 1, 1, 1, 3'b000);
    add(0, 3'b010, 3'b000, 7, 3'b010, 1, 1, 1, 3'b010);
    add(0, 3'b000, 3'b000, 7, 3'b000, 0, 0, 0, 3'b000);

    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      req         = vecs[i].req;
      lock        = vecs[i].lock;
      wait_cycles = vecs[i].wc;
      step();
      check($sformatf("v%0d gnt", i),        32'(gnt),        32'(vecs[i].gnt));
      check($sformatf("v%0d gnt_idx", i),    32'(gnt_idx),    32'(vecs[i].idx));
      check($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].busy));
      check($sformatf("v%0d mem_strobe", i), 32'(mem_strobe), 32'(vecs[i].strobe));
      check($sformatf("v%0d done", i),       32'(done),       32'(vecs[i].done));
    end

    // Maximum-length access: wait 15 -> 16 strobe cycles, done in the last.
    reset = 1'b0; req = 3'b010; lock = '0; wait_cycles = 4'd15;
    strobes = 0;
    seen    = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (mem_strobe) strobes++;
      if (done != '0) begin
        seen = 1'b1;
        check("maxw done", 32'(done), 32'(3'b010));
        req  = '0;
      end
    end
    check("maxw done seen", 32'(seen), 32'd1);
    check("maxw strobe cycles", 32'(strobes), 32'd16);
    step();
    check("maxw idle busy", 32'(busy), 32'd0);
    check("maxw idle gnt", 32'(gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
